// File: rtl/reg_dump_uart.sv
// reg_dump_uart
//    Debug readout engine for the pipeline's register-inspection port. On a
//    start request it sends one framed snapshot over a UART 8N1 TX line: a sync
//    byte 0xA5, then the PC, then registers FIRST_REG..LAST_REG. Every word is
//    sent as 4 bytes, MSB first, and every byte is sent LSB first.
//
//    Optional feature (compile-time macro REG_DUMP_CHECKSUM_EN):
//       when defined, one more byte follows the last register. It holds the XOR
//       of every byte after the sync byte.
//
//    Parameters
//       CLKS_PER_BIT : clock cycles per UART bit (>= 2)
//       FIRST_REG    : first register index dumped
//       LAST_REG     : last register index dumped (>= FIRST_REG)
//
//    Ports
//       clock    in   1 : rising-edge clock
//       reset    in   1 : synchronous, active-high
//       start    in   1 : single-cycle dump request, ignored while busy or done
//       pc_in    in  32 : pipeline pc_out
//       reg_data in  32 : pipeline register_out
//       reg_sel  out  5 : pipeline register_switch
//       tx       out  1 : UART serial out, idles high
//       busy     out  1 : high while a frame is in progress
//       done     out  1 : one-cycle pulse after the last stop bit
//
//    state     | meaning
//    ----------+-------------------------------------------------------------
//    IDLE      | line high, waiting for start
//    START_BIT | driving the start bit; register capture and reg_sel advance
//    DATA_BITS | shifting out 8 data bits, LSB first
//    STOP_BIT  | driving the stop bit; on its last cycle, pick the next byte
//    NEXT_BYTE | never occupied: folded into the last STOP_BIT cycle
module reg_dump_uart #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIRST_REG    = 0,
   parameter int LAST_REG     = 31
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] pc_in,
   input  logic [31:0] reg_data,
   output logic [4:0]  reg_sel,
   output logic        tx,
   output logic        busy,
   output logic        done
);

   localparam int                BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [4:0]        SEL_FIRST = 5'(FIRST_REG);
   localparam logic [4:0]        SEL_LAST  = 5'(LAST_REG);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] START_BIT = 3'd1;
   localparam logic [2:0] DATA_BITS = 3'd2;
   localparam logic [2:0] STOP_BIT  = 3'd3;
   localparam logic [2:0] NEXT_BYTE = 3'd4;

   // Frame segment currently being sent.
   localparam logic [1:0] SEG_SYNC = 2'd0;
   localparam logic [1:0] SEG_PC   = 2'd1;
   localparam logic [1:0] SEG_REG  = 2'd2;
`ifdef REG_DUMP_CHECKSUM_EN
   localparam logic [1:0] SEG_CSUM = 2'd3;
   logic [7:0] csum;
`endif

   logic [2:0]        state;
   logic [BAUD_W-1:0] baud_cnt;
   logic [2:0]        bit_cnt;
   logic [1:0]        seg;
   logic [1:0]        byte_idx;
   logic [31:0]       word_buf;
   logic [6:0]        shreg;
   logic              last_word;
   logic [7:0]        cur_byte;
   logic              baud_end;

   assign baud_end = (baud_cnt == BAUD_LAST);

   // The byte is only needed at the end of START_BIT. A register word captured
   // on the first START_BIT cycle is therefore already in word_buf by then.
   always_comb begin
      cur_byte = word_buf[7:0];
      case (byte_idx)
         2'd0:    cur_byte = word_buf[31:24];
         2'd1:    cur_byte = word_buf[23:16];
         2'd2:    cur_byte = word_buf[15:8];
         default: cur_byte = word_buf[7:0];
      endcase
      if (seg == SEG_SYNC) cur_byte = 8'hA5;
`ifdef REG_DUMP_CHECKSUM_EN
      if (seg == SEG_CSUM) cur_byte = csum;
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         seg       <= SEG_SYNC;
         byte_idx  <= '0;
         word_buf  <= '0;
         shreg     <= '0;
         last_word <= 1'b0;
         reg_sel   <= SEL_FIRST;
         tx        <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
         csum      <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // done is high only in the cycle right after a frame. A start
               // in that cycle belongs to the frame that just ended.
               if (start && !done) begin
                  word_buf <= pc_in;
                  reg_sel  <= SEL_FIRST;
                  seg      <= SEG_SYNC;
                  byte_idx <= '0;
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  tx       <= 1'b0;
                  busy     <= 1'b1;
                  state    <= START_BIT;
`ifdef REG_DUMP_CHECKSUM_EN
                  csum     <= '0;
`endif
               end
            end

            START_BIT: begin
               if ((baud_cnt == '0) && (seg == SEG_REG)) begin
                  if (byte_idx == 2'd0) begin
                     word_buf  <= reg_data;
                     last_word <= (reg_sel == SEL_LAST);
                  end
                  // Advancing during byte 3 gives the pipeline a full byte
                  // time to settle before the next capture.
                  if ((byte_idx == 2'd3) && !last_word) reg_sel <= reg_sel + 5'd1;
               end
               if (baud_end) begin
                  baud_cnt <= '0;
                  shreg    <= cur_byte[7:1];
                  tx       <= cur_byte[0];
                  state    <= DATA_BITS;
`ifdef REG_DUMP_CHECKSUM_EN
                  if ((seg == SEG_PC) || (seg == SEG_REG)) csum <= csum ^ cur_byte;
`endif
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end

            DATA_BITS: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (bit_cnt == 3'd7) begin
                     bit_cnt <= '0;
                     tx      <= 1'b1;
                     state   <= STOP_BIT;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     tx      <= shreg[0];
                     shreg   <= {1'b0, shreg[6:1]};
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end

            STOP_BIT: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  tx       <= 1'b0;
                  state    <= START_BIT;
                  byte_idx <= byte_idx + 2'd1;
                  case (seg)
                     SEG_SYNC: begin
                        seg      <= SEG_PC;
                        byte_idx <= '0;
                     end
                     SEG_PC: begin
                        if (byte_idx == 2'd3) seg <= SEG_REG;
                     end
                     SEG_REG: begin
                        if ((byte_idx == 2'd3) && last_word) begin
`ifdef REG_DUMP_CHECKSUM_EN
                           seg      <= SEG_CSUM;
                           byte_idx <= '0;
`else
                           state    <= IDLE;
                           tx       <= 1'b1;
                           busy     <= 1'b0;
                           done     <= 1'b1;
                           reg_sel  <= SEL_FIRST;
                           seg      <= SEG_SYNC;
                           byte_idx <= '0;
`endif
                        end
                     end
                     default: begin
                        state    <= IDLE;
                        tx       <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        reg_sel  <= SEL_FIRST;
                        seg      <= SEG_SYNC;
                        byte_idx <= '0;
                     end
                  endcase
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end

            NEXT_BYTE: begin
               state   <= IDLE;
               tx      <= 1'b1;
               busy    <= 1'b0;
               reg_sel <= SEL_FIRST;
            end

            default: begin
               state   <= IDLE;
               tx      <= 1'b1;
               busy    <= 1'b0;
               reg_sel <= SEL_FIRST;
            end
         endcase
      end
   end

endmodule
